mem_stage_access: RTL and testbench
===================================

// Module: mem_stage_access
// PURPOSE
// - Consumer end of the EX/MEM pipeline interface: takes the registered Mem* control/data and runs the data-memory access.
// - Drives a req/ack handshake to data memory, stalls upstream stages while the access is outstanding,
//   formats load data and registers MEM/WB outputs for the write-back stage.
// - Also signals a bus error if an ack never arrives within the timeout.
// PARAMETERS
// - TIMEOUT    default 16  max cycles waiting for dm_ack before bus error (>=2)
// - DATA_W     default 64  data/address width
// - REG_W      default 5   register address width
// PORTS
// - clk              in   1       clock
// - reset            in   1       asynchronous, active-high reset
// - MemMem2Reg       in   1       select load data for write-back
// - MemRegWrite      in   1       instruction writes Rd
// - MemMemWrite      in   1       store
// - MemMemRead       in   1       load
// - Memxfer_size     in   4       transfer bytes: 1,2,4,8 (other values = 8)
// - MemAw            in   REG_W   destination register
// - MemALUOut        in   DATA_W  effective address / ALU result
// - MemDb            in   DATA_W  store data
// - dm_req, dm_we    out  1       memory request / write enable
// - dm_addr          out  DATA_W  aligned address (addr[2:0]=0)
// - dm_wdata         out  DATA_W  store data shifted to byte lane addr[2:0]
// - dm_be            out  8       byte enables
// - dm_ack           in   1       memory completion, 1-cycle pulse
// - dm_rdata         in   DATA_W  read data, valid with dm_ack
// - stall            out  1       hold IF/ID/EX and EX/MEM registers
// - bus_err          out  1       sticky timeout flag
// - WbMem2Reg, WbRegWrite  out  1 registered MEM/WB controls
// - WbAw             out  REG_W   registered destination
// - WbALUOut, WbRdata out DATA_W  registered ALU result / formatted load data
// BEHAVIOUR
// - Reset: state IDLE, every output 0, timeout counter 0, bus_err 0.
// - FSM IDLE -> WAIT when (MemMemRead|MemMemWrite) and no fault; dm_req/dm_we/dm_addr/dm_be/dm_wdata driven from the cycle of entry.
// - WAIT: hold dm_req and all request fields stable until dm_ack; counter++ each cycle.
// - WAIT & dm_ack -> IDLE: MEM/WB captures at that edge; stall drops.
// - WAIT & counter==TIMEOUT-1 & !dm_ack -> IDLE: bus_err set; WbRegWrite=0 for that instruction.
// - stall = (IDLE & memop & !fault) | (WAIT & !dm_ack): combinational.
// - While stall=1 the MEM/WB register loads a bubble (WbRegWrite=0, WbMem2Reg=0).
// - Non-memory ops: MEM/WB loads inputs directly next edge, 1-cycle latency, no stall.
// - Loads: a 1-cycle ack after req gives 2 stall cycles (req cycle + wait cycle); ack same cycle as entry is not possible.
// - Load format: bytes taken from dm_rdata at lane addr[2:0], zero-extended to DATA_W per size.
// - dm_be = ((1<<size)-1) << addr[2:0], truncated to 8 bits.
// - Addresses crossing 8-byte lanes are truncated unless MISALIGN_TRAP_EN is defined.
// - dm_ack seen in IDLE: ignored.
// - Reset mid-WAIT: abort immediately, dm_req=0, no write-back.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined: addr % size != 0 is a fault. No dm_req is issued, bus_err is set, a bubble goes to MEM/WB, no stall.
// - MISALIGN_TRAP_EN not defined: no check; lane truncation as above.
// STRUCTURE
// - Package mem_stage_pkg:
//   - state enum {IDLE, WAIT}
//   - XFER_B/H/W/D constants (1,2,4,8)
//   - function size_mask(xfer_size)
// - Sub-module load_formatter: combinational lane select + zero-extend.
// - MEM/WB uses the existing register / D_FF cells with write_en=1.
// TESTING
// - ALU op (MemRegWrite=1, Aw=3, ALUOut=0x55): WbALUOut=0x55 and WbRegWrite=1 next edge; stall never asserts.
// - LDUR, addr 0x100, size 8, ack 1 cycle after req, rdata 0xDEADBEEF_CAFEF00D:
//   stall high 2 cycles; WbRdata=0xDEADBEEFCAFEF00D, WbMem2Reg=1.
// - LDURB, addr 0x103, rdata 0x11223344_55667788: dm_be=0x08, WbRdata=0x55.
// - STUR, addr 0x8, size 4, Db=0xAABBCCDD: dm_we=1, dm_be=0x0F, dm_wdata[31:0]=0xAABBCCDD; req held 3 cycles of delayed ack.
// - No ack for TIMEOUT=16 cycles: bus_err=1 at cycle 16, stall drops, WbRegWrite=0.
// - Reset asserted mid-WAIT: dm_req=0 and outputs 0 immediately.
// - With MISALIGN_TRAP_EN, size 4 at addr 0x2: no dm_req, bus_err=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_stage_pkg
// Brief  : Shared types, transfer-size constants and byte-mask helper for
//          the MEM stage.
// Rev    : 1.0  initial release
// ============================================================================
package mem_stage_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [3:0] XFER_B = 4'd1;
    localparam logic [3:0] XFER_H = 4'd2;
    localparam logic [3:0] XFER_W = 4'd4;
    localparam logic [3:0] XFER_D = 4'd8;

    // Unsupported size codes behave as a doubleword access.
    function automatic logic [7:0] size_mask(input logic [3:0] xfer_size);
        case (xfer_size)
            XFER_B:  size_mask = 8'h01;
            XFER_H:  size_mask = 8'h03;
            XFER_W:  size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_formatter.sv
`default_nettype none
// ============================================================================
// Module : load_formatter
// Brief  : Selects the addressed byte lane of read data and zero-extends it
//          to the full data width according to the transfer size.
// Rev    : 1.0  initial release
// ============================================================================
module load_formatter
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [2:0]        i_lane,
    input  logic [3:0]        i_size,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_shifted;
    logic [7:0]        w_mask;

    // Bytes that would fall past the 8-byte lane are dropped, not wrapped.
    always_comb begin
        w_shifted = i_rdata >> {i_lane, 3'b000};
        w_mask    = size_mask(i_size);
        o_data    = '0;
        for (int i = 0; i < 8; i++) begin
            if (w_mask[i] && ((i + int'(i_lane)) < 8)) begin
                o_data[i*8 +: 8] = w_shifted[i*8 +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_access.sv
`default_nettype none
// ============================================================================
// Module : mem_stage_access
// Brief  : MEM stage: req/ack data-memory access with stall, timeout bus
//          error, load formatting and MEM/WB registers.
//          Optional MISALIGN_TRAP_EN: misaligned accesses fault instead of
//          being lane-truncated.
// Rev    : 1.0  initial release
// ============================================================================
module mem_stage_access
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int DATA_W  = 64,
    parameter int REG_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemMem2Reg,
    input  logic              MemRegWrite,
    input  logic              MemMemWrite,
    input  logic              MemMemRead,
    input  logic [3:0]        Memxfer_size,
    input  logic [REG_W-1:0]  MemAw,
    input  logic [DATA_W-1:0] MemALUOut,
    input  logic [DATA_W-1:0] MemDb,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic [7:0]        dm_be,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              stall,
    output logic              bus_err,
    output logic              WbMem2Reg,
    output logic              WbRegWrite,
    output logic [REG_W-1:0]  WbAw,
    output logic [DATA_W-1:0] WbALUOut,
    output logic [DATA_W-1:0] WbRdata
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_lane;
    logic [3:0]        r_size;

    logic              w_memop;
    logic              w_fault;
    logic              w_bubble;
    logic [2:0]        w_lane;
    logic [7:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_addr_al;
    logic [DATA_W-1:0] w_fmt;

    assign w_lane    = MemALUOut[2:0];
    assign w_memop   = MemMemRead | MemMemWrite;
    assign w_be      = size_mask(Memxfer_size) << w_lane;
    assign w_wdata   = MemDb << {w_lane, 3'b000};
    assign w_addr_al = {MemALUOut[DATA_W-1:3], 3'b000};

`ifdef MISALIGN_TRAP_EN
    logic [7:0] w_smask;
    assign w_smask = size_mask(Memxfer_size);
    // {m[7],m[3],m[1]} is (size-1) for the four legal sizes.
    assign w_fault = w_memop && (r_state == IDLE) &&
                     (|(w_lane & {w_smask[7], w_smask[3], w_smask[1]}));
`else
    assign w_fault = 1'b0;
`endif

    assign stall = !reset &&
                   (((r_state == IDLE) && w_memop && !w_fault) ||
                    ((r_state == WAIT) && !dm_ack));
    assign w_bubble = stall || w_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_lane   <= '0;
            r_size   <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            dm_be    <= '0;
            bus_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_memop && !w_fault) begin
                        r_state  <= WAIT;
                        r_cnt    <= '0;
                        r_lane   <= w_lane;
                        r_size   <= Memxfer_size;
                        dm_req   <= 1'b1;
                        dm_we    <= MemMemWrite;
                        dm_addr  <= w_addr_al;
                        dm_wdata <= w_wdata;
                        dm_be    <= w_be;
                    end else if (w_fault) begin
                        bus_err  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (dm_ack || (r_cnt == c_cnt_max)) begin
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                        dm_req   <= 1'b0;
                        dm_we    <= 1'b0;
                        dm_addr  <= '0;
                        dm_wdata <= '0;
                        dm_be    <= '0;
                        if (!dm_ack) begin
                            bus_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    load_formatter #(
        .DATA_W (DATA_W)
    ) u_fmt (
        .i_rdata (dm_rdata),
        .i_lane  (r_lane),
        .i_size  (r_size),
        .o_data  (w_fmt)
    );

    // MEM/WB: controls are squashed while stalled or faulting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WbMem2Reg  <= 1'b0;
            WbRegWrite <= 1'b0;
            WbAw       <= '0;
            WbALUOut   <= '0;
            WbRdata    <= '0;
        end else begin
            WbMem2Reg  <= w_bubble ? 1'b0 : MemMem2Reg;
            WbRegWrite <= w_bubble ? 1'b0 : MemRegWrite;
            WbAw       <= MemAw;
            WbALUOut   <= MemALUOut;
            WbRdata    <= w_fmt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_access.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_stage_access
// Brief  : Directed self-checking bench for mem_stage_access.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_stage_access;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              MemMem2Reg, MemRegWrite, MemMemWrite, MemMemRead;
    logic [3:0]        Memxfer_size;
    logic [REG_W-1:0]  MemAw;
    logic [DATA_W-1:0] MemALUOut, MemDb;
    logic              dm_req, dm_we;
    logic [DATA_W-1:0] dm_addr, dm_wdata;
    logic [7:0]        dm_be;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;
    logic              stall, bus_err;
    logic              WbMem2Reg, WbRegWrite;
    logic [REG_W-1:0]  WbAw;
    logic [DATA_W-1:0] WbALUOut, WbRdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_access #(
        .TIMEOUT (16),
        .DATA_W  (DATA_W),
        .REG_W   (REG_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemMem2Reg   (MemMem2Reg),
        .MemRegWrite  (MemRegWrite),
        .MemMemWrite  (MemMemWrite),
        .MemMemRead   (MemMemRead),
        .Memxfer_size (Memxfer_size),
        .MemAw        (MemAw),
        .MemALUOut    (MemALUOut),
        .MemDb        (MemDb),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_be        (dm_be),
        .dm_ack       (dm_ack),
        .dm_rdata     (dm_rdata),
        .stall        (stall),
        .bus_err      (bus_err),
        .WbMem2Reg    (WbMem2Reg),
        .WbRegWrite   (WbRegWrite),
        .WbAw         (WbAw),
        .WbALUOut     (WbALUOut),
        .WbRdata      (WbRdata)
    );

    task automatic clear_inputs();
        MemMem2Reg   = 1'b0;
        MemRegWrite  = 1'b0;
        MemMemWrite  = 1'b0;
        MemMemRead   = 1'b0;
        Memxfer_size = 4'd8;
        MemAw        = '0;
        MemALUOut    = '0;
        MemDb        = '0;
        dm_ack       = 1'b0;
        dm_rdata     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL reset_dm_req got %0h want 0", dm_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h want 0", stall); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %0h want 0", bus_err); end
        checks++; if (WbRegWrite !== 1'b0) begin errors++; $display("FAIL reset_wbregwrite got %0h want 0", WbRegWrite); end
        checks++; if (dm_be !== 8'h00) begin errors++; $display("FAIL reset_dm_be got %0h want 0", dm_be); end
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_alu();
        MemRegWrite = 1'b1;
        MemAw       = 5'd3;
        MemALUOut   = 64'h55;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %0h want 0", stall); end
        tick();
        checks++; if (WbALUOut !== 64'h55) begin errors++; $display("FAIL alu_wbaluout got %0h want 55", WbALUOut); end
        checks++; if (WbRegWrite !== 1'b1) begin errors++; $display("FAIL alu_wbregwrite got %0h want 1", WbRegWrite); end
        checks++; if (WbAw !== 5'd3) begin errors++; $display("FAIL alu_wbaw got %0h want 3", WbAw); end
        // stray ack while idle must be ignored
        clear_inputs();
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        #1;
        checks++; if (dm_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL idle_ack got req=%0h stall=%0h want 0 0", dm_req, stall); end
    endtask

    task automatic test_load_dword();
        int stall_cycles = 0;
        MemMemRead   = 1'b1;
        MemMem2Reg   = 1'b1;
        MemRegWrite  = 1'b1;
        Memxfer_size = 4'd8;
        MemAw        = 5'd7;
        MemALUOut    = 64'h100;
        #1;
        if (stall === 1'b1) stall_cycles++;
        tick();
        checks++; if (dm_req !== 1'b1 || dm_we !== 1'b0) begin errors++; $display("FAIL ldur_req got req=%0h we=%0h want 1 0", dm_req, dm_we); end
        checks++; if (dm_addr !== 64'h100) begin errors++; $display("FAIL ldur_addr got %0h want 100", dm_addr); end
        checks++; if (dm_be !== 8'hFF) begin errors++; $display("FAIL ldur_be got %0h want ff", dm_be); end
        checks++; if (WbRegWrite !== 1'b0) begin errors++; $display("FAIL ldur_bubble got %0h want 0", WbRegWrite); end
        if (stall === 1'b1) stall_cycles++;
        tick();
        dm_ack   = 1'b1;
        dm_rdata = 64'hDEADBEEF_CAFEF00D;
        #1;
        if (stall === 1'b1) stall_cycles++;
        checks++; if (stall_cycles != 2) begin errors++; $display("FAIL ldur_stall_cycles got %0d want 2", stall_cycles); end
        tick();
        dm_ack = 1'b0;
        checks++; if (WbRdata !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL ldur_rdata got %0h want deadbeefcafef00d", WbRdata); end
        checks++; if (WbMem2Reg !== 1'b1 || WbRegWrite !== 1'b1) begin errors++; $display("FAIL ldur_wbctl got m2r=%0h rw=%0h want 1 1", WbMem2Reg, WbRegWrite); end
        checks++; if (WbAw !== 5'd7) begin errors++; $display("FAIL ldur_wbaw got %0h want 7", WbAw); end
        checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL ldur_req_drop got %0h want 0", dm_req); end
        clear_inputs();
        #1;
    endtask

    task automatic test_load_byte();
        MemMemRead   = 1'b1;
        MemMem2Reg   = 1'b1;
        MemRegWrite  = 1'b1;
        Memxfer_size = 4'd1;
        MemAw        = 5'd9;
        MemALUOut    = 64'h103;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ldurb_stall got %0h want 1", stall); end
        tick();
        checks++; if (dm_be !== 8'h08) begin errors++; $display("FAIL ldurb_be got %0h want 08", dm_be); end
        checks++; if (dm_addr !== 64'h100) begin errors++; $display("FAIL ldurb_addr got %0h want 100", dm_addr); end
        dm_ack   = 1'b1;
        dm_rdata = 64'h11223344_55667788;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ldurb_stall_ack got %0h want 0", stall); end
        tick();
        dm_ack = 1'b0;
        checks++; if (WbRdata !== 64'h55) begin errors++; $display("FAIL ldurb_rdata got %0h want 55", WbRdata); end
        checks++; if (WbMem2Reg !== 1'b1) begin errors++; $display("FAIL ldurb_m2r got %0h want 1", WbMem2Reg); end
        clear_inputs();
        #1;
    endtask

    task automatic test_store();
        MemMemWrite  = 1'b1;
        Memxfer_size = 4'd4;
        MemALUOut    = 64'h8;
        MemDb        = 64'hAABBCCDD;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++; if (dm_req !== 1'b1 || dm_we !== 1'b1) begin errors++; $display("FAIL stur_req_c%0d got req=%0h we=%0h want 1 1", c, dm_req, dm_we); end
            checks++; if (dm_be !== 8'h0F || dm_wdata !== 64'hAABBCCDD || dm_addr !== 64'h8) begin errors++; $display("FAIL stur_fields_c%0d got be=%0h wd=%0h a=%0h want 0f aabbccdd 8", c, dm_be, dm_wdata, dm_addr); end
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stur_stall_c%0d got %0h want 1", c, stall); end
            tick();
        end
        dm_ack = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stur_stall_ack got %0h want 0", stall); end
        tick();
        clear_inputs();
        #1;
        checks++; if (dm_req !== 1'b0 || dm_we !== 1'b0) begin errors++; $display("FAIL stur_done got req=%0h we=%0h want 0 0", dm_req, dm_we); end
    endtask

    task automatic test_lanes();
        MemMemWrite  = 1'b1;
        Memxfer_size = 4'd2;
        MemALUOut    = 64'hA;
        MemDb        = 64'h1234;
        tick();
        checks++; if (dm_be !== 8'h0C || dm_wdata !== 64'h12340000 || dm_addr !== 64'h8) begin errors++; $display("FAIL sturh_lane got be=%0h wd=%0h a=%0h want 0c 12340000 8", dm_be, dm_wdata, dm_addr); end
        dm_ack = 1'b1;
        tick();
        clear_inputs();
`ifndef MISALIGN_TRAP_EN
        MemMemRead   = 1'b1;
        MemRegWrite  = 1'b1;
        MemMem2Reg   = 1'b1;
        Memxfer_size = 4'd4;
        MemALUOut    = 64'h6;
        tick();
        checks++; if (dm_be !== 8'hC0) begin errors++; $display("FAIL trunc_be got %0h want c0", dm_be); end
        dm_ack   = 1'b1;
        dm_rdata = 64'h11223344_55667788;
        tick();
        checks++; if (WbRdata !== 64'h1122) begin errors++; $display("FAIL trunc_rdata got %0h want 1122", WbRdata); end
        clear_inputs();
`endif
        #1;
    endtask

    task automatic test_timeout();
        MemMemRead   = 1'b1;
        MemRegWrite  = 1'b1;
        MemMem2Reg   = 1'b1;
        Memxfer_size = 4'd8;
        MemALUOut    = 64'h200;
        for (int c = 0; c < 16; c++) tick();
        checks++; if (bus_err !== 1'b0 || dm_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL tmo_pre got err=%0h req=%0h stall=%0h want 0 1 1", bus_err, dm_req, stall); end
        MemMemRead = 1'b0;
        tick();
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL tmo_bus_err got %0h want 1", bus_err); end
        checks++; if (stall !== 1'b0 || dm_req !== 1'b0) begin errors++; $display("FAIL tmo_release got stall=%0h req=%0h want 0 0", stall, dm_req); end
        checks++; if (WbRegWrite !== 1'b0) begin errors++; $display("FAIL tmo_wbregwrite got %0h want 0", WbRegWrite); end
        clear_inputs();
        tick();
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %0h want 1", bus_err); end
    endtask

    task automatic test_reset_mid_wait();
        MemMemRead   = 1'b1;
        MemRegWrite  = 1'b1;
        Memxfer_size = 4'd8;
        MemALUOut    = 64'h40;
        tick();
        tick();
        checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL rst_wait_pre got %0h want 1", dm_req); end
        reset = 1'b1;
        #1;
        checks++; if (dm_req !== 1'b0 || dm_be !== 8'h00 || stall !== 1'b0) begin errors++; $display("FAIL rst_wait_req got req=%0h be=%0h stall=%0h want 0 0 0", dm_req, dm_be, stall); end
        checks++; if (bus_err !== 1'b0 || WbALUOut !== 64'h0) begin errors++; $display("FAIL rst_wait_outs got err=%0h alu=%0h want 0 0", bus_err, WbALUOut); end
        clear_inputs();
        #2 reset = 1'b0;
        tick();
        checks++; if (WbRegWrite !== 1'b0 || dm_req !== 1'b0) begin errors++; $display("FAIL rst_wait_nowb got rw=%0h req=%0h want 0 0", WbRegWrite, dm_req); end
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign();
        MemMemRead   = 1'b1;
        MemRegWrite  = 1'b1;
        Memxfer_size = 4'd4;
        MemALUOut    = 64'h2;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %0h want 0", stall); end
        tick();
        checks++; if (dm_req !== 1'b0 || bus_err !== 1'b1) begin errors++; $display("FAIL mis_fault got req=%0h err=%0h want 0 1", dm_req, bus_err); end
        checks++; if (WbRegWrite !== 1'b0) begin errors++; $display("FAIL mis_bubble got %0h want 0", WbRegWrite); end
        clear_inputs();
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load_dword();
        test_load_byte();
        test_store();
        test_lanes();
        test_timeout();
        test_reset_mid_wait();
`ifdef MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
